serial_frame_rx: RTL



---
 rtl/serial_frame_rx_if.sv | 16 +
 rtl/serial_frame_rx.sv | 80 ++++++++
 2 files changed

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial bit input (din, din_en) and recovered frame outputs (dout, dout_valid, parity_err, in_frame, frame_cnt, err_cnt)
interface serial_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 8
);
  logic din;
  logic din_en;
  logic [DATA_W-1:0] dout;
  logic dout_valid;
  logic parity_err;
  logic in_frame;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master(output din, din_en, input dout, dout_valid, parity_err, in_frame, frame_cnt, err_cnt);
  modport slave(input din, din_en, output dout, dout_valid, parity_err, in_frame, frame_cnt, err_cnt);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: sync-hunting serial byte receiver with even parity; ports clk, rst (sync active-high), bus (din/din_en in, dout/dout_valid/parity_err/in_frame/frame_cnt/err_cnt out)
module serial_frame_rx #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1011,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  serial_frame_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;
  state_t state_q;
  logic [SYNC_W-2:0] hist_q;
  logic [SYNC_W-1:0] hist_d;
  logic [DATA_W-1:0] data_q, data_d, dout_q;
  logic [BW-1:0] bit_cnt_q;
  logic dout_valid_q, parity_err_q, in_frame_q, ok_d;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
  always_comb begin
    hist_d = {hist_q, bus.din};
    data_d = {data_q[DATA_W-2:0], bus.din};
    ok_d = ~(^data_q ^ bus.din);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      hist_q <= '0;
      data_q <= '0;
      bit_cnt_q <= '0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      in_frame_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      if (bus.din_en) begin
        case (state_q)
          HUNT: begin
            hist_q <= hist_d[SYNC_W-2:0];
            if (hist_d == SYNC_WORD) begin
              state_q <= DATA;
              bit_cnt_q <= '0;
              data_q <= '0;
              in_frame_q <= 1'b1;
            end
          end
          DATA: begin
            data_q <= data_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_W - 1)) state_q <= PARITY;
          end
          default: begin
            if (ok_d) begin
              dout_q <= data_q;
              dout_valid_q <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end else begin
              parity_err_q <= 1'b1;
              err_cnt_q <= err_cnt_q + 1'b1;
            end
            state_q <= HUNT;
            hist_q <= '0;
            in_frame_q <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.dout = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.in_frame = in_frame_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt = err_cnt_q;
endmodule
